button_debounce: RTL and testbench

//  Input-side counterpart of the LED blinker: samples a raw, bouncing push-button pin,

---
 rtl/button_debounce_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/button_debounce.sv | 149 ++++++++++++++
 tb/tb_button_debounce.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/button_debounce_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding and clock defaults.
// No logic, no latency.
// No flow control; constants and types only.
package button_debounce_pkg;

  // Board clock used when a build does not override CLK_HZ.
  localparam int CLK_HZ_DEFAULT = 25_000_000;

  // Debounce FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DB_PRESS   = 2'd1,
    ST_HELD       = 2'd2,
    ST_DB_RELEASE = 2'd3
  } db_state_t;

  // Converts a duration in milliseconds into clock cycles at clk_hz.
  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input pin.
// Latency: 2 clk cycles from pin to q.
// No flow control; samples every cycle.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; reset loads the idle level so no false edge follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Debounces a raw push-button pin into a clean level, press/release/long-press strobes and a press count.
// Latency: pin change first sampled at edge E shows on outputs after edge E+DB_CYCLES+2.
// No flow control; strobes are single-cycle and must be consumed when they occur.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int CLK_HZ        = CLK_HZ_DEFAULT,
  parameter int DEBOUNCE_MS   = 10,
  parameter int LONG_PRESS_MS = 1000,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       pressed,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_count
);

  localparam int DB_CYCLES   = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int LONG_CYCLES = ms_to_cycles(CLK_HZ, LONG_PRESS_MS);
  localparam int DB_W        = $clog2(DB_CYCLES + 1);
  localparam int HOLD_W      = $clog2(LONG_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);

  // Synchronizer idles at the pin's released level.
  localparam logic SYNC_RST = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic btn_sync;
  logic btn_act;

  db_state_t         state,         state_nx;
  logic [DB_W-1:0]   db_cnt,        db_cnt_nx;
  logic [HOLD_W-1:0] hold_cnt,      hold_cnt_nx;
  logic              long_done,     long_done_nx;
  logic              pressed_nx;
  logic              press_pulse_nx;
  logic              release_pulse_nx;
  logic              long_pulse_nx;
  logic [7:0]        press_count_nx;

  sync_2ff #(
    .RST_VAL (SYNC_RST)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (btn_sync)
  );

  // Normalise polarity so 1 always means "button down".
  assign btn_act = (ACTIVE_LOW != 0) ? ~btn_sync : btn_sync;

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      long_done     <= 1'b0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      state         <= state_nx;
      db_cnt        <= db_cnt_nx;
      hold_cnt      <= hold_cnt_nx;
      long_done     <= long_done_nx;
      pressed       <= pressed_nx;
      press_pulse   <= press_pulse_nx;
      release_pulse <= release_pulse_nx;
      long_pulse    <= long_pulse_nx;
      press_count   <= press_count_nx;
    end
  end

  // Next-state and next-output decode; strobes default low so they last one cycle.
  always_comb begin
    state_nx         = state;
    db_cnt_nx        = db_cnt;
    hold_cnt_nx      = hold_cnt;
    long_done_nx     = long_done;
    pressed_nx       = pressed;
    press_pulse_nx   = 1'b0;
    release_pulse_nx = 1'b0;
    long_pulse_nx    = 1'b0;
    press_count_nx   = press_count;

    case (state)
      ST_IDLE: begin
        if (btn_act) begin
          state_nx  = ST_DB_PRESS;
          db_cnt_nx = '0;
        end
      end

      ST_DB_PRESS: begin
        if (!btn_act) begin
          // Too short to be a press: drop back without any event.
          state_nx = ST_IDLE;
        end else if (db_cnt == DB_LAST) begin
          state_nx       = ST_HELD;
          pressed_nx     = 1'b1;
          press_pulse_nx = 1'b1;
          press_count_nx = press_count + 8'd1;
          hold_cnt_nx    = '0;
          long_done_nx   = 1'b0;
        end else begin
          db_cnt_nx = db_cnt + DB_W'(1);
        end
      end

      ST_HELD: begin
        if (!btn_act) begin
          state_nx  = ST_DB_RELEASE;
          db_cnt_nx = '0;
        end else begin
          if (hold_cnt != LONG_LAST) begin
            hold_cnt_nx = hold_cnt + HOLD_W'(1);
          end
          if ((hold_cnt == LONG_LAST) && !long_done) begin
            long_pulse_nx = 1'b1;
            long_done_nx  = 1'b1;
          end
        end
      end

      default: begin // ST_DB_RELEASE; hold_cnt stays frozen here
        if (btn_act) begin
          // Release bounce: resume holding where the hold count left off.
          state_nx = ST_HELD;
        end else if (db_cnt == DB_LAST) begin
          state_nx         = ST_IDLE;
          pressed_nx       = 1'b0;
          release_pulse_nx = 1'b1;
        end else begin
          db_cnt_nx = db_cnt + DB_W'(1);
        end
      end
    endcase
  end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce at 1 kHz: DB=4 cycles, LONG=20 cycles, active-low pin.
// Latency checked against the E+6 press/release timing.
// No flow control; every cycle's strobes are tallied.
module tb_button_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_in;
  logic       pressed;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [7:0] press_count;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int press_n, release_n, long_n, clash_n;
  int press_at, release_at, long_at;
  int e0;

  button_debounce #(
    .CLK_HZ        (1000),
    .DEBOUNCE_MS   (4),
    .LONG_PRESS_MS (20),
    .ACTIVE_LOW    (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_in        (btn_in),
    .pressed       (pressed),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .press_count   (press_count)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then sample and tally the strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (press_pulse === 1'b1) begin
      press_n++;
      press_at = cyc;
    end
    if (release_pulse === 1'b1) begin
      release_n++;
      release_at = cyc;
    end
    if (long_pulse === 1'b1) begin
      long_n++;
      long_at = cyc;
    end
    if (press_pulse === 1'b1 && release_pulse === 1'b1) clash_n++;
    if (press_pulse === 1'b1 && long_pulse === 1'b1) clash_n++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr();
    press_n    = 0;
    release_n  = 0;
    long_n     = 0;
    press_at   = -1;
    release_at = -1;
    long_at    = -1;
  endtask

  initial begin
    clash_n = 0;
    clr();
    rst    = 1'b1;
    btn_in = 1'b1;

    // Reset
    ticks(3);
    chk("rst_pressed", 32'(pressed), 0);
    chk("rst_press_pulse", 32'(press_pulse), 0);
    chk("rst_release_pulse", 32'(release_pulse), 0);
    chk("rst_long_pulse", 32'(long_pulse), 0);
    chk("rst_count", 32'(press_count), 0);
    rst = 1'b0;
    ticks(5);
    chk("idle_no_press", 32'(press_n), 0);

    // Clean press held 30 cycles, then released
    clr();
    btn_in = 1'b0;
    e0 = cyc + 1;
    ticks(6);
    chk("clean_pre_pressed", 32'(pressed), 0);
    chk("clean_pre_strobe", 32'(press_n), 0);
    tick();
    chk("clean_press_pulse", 32'(press_pulse), 1);
    chk("clean_pressed", 32'(pressed), 1);
    chk("clean_count", 32'(press_count), 1);
    tick();
    chk("clean_pulse_one_cycle", 32'(press_pulse), 0);
    ticks(22);
    btn_in = 1'b1;
    ticks(12);
    chk("clean_press_n", 32'(press_n), 1);
    chk("clean_long_n", 32'(long_n), 1);
    chk("clean_long_at", 32'(long_at - e0), 26);
    chk("clean_release_n", 32'(release_n), 1);
    chk("clean_release_at", 32'(release_at - e0), 36);
    chk("clean_released", 32'(pressed), 0);

    // Glitch of 3 cycles is rejected
    clr();
    btn_in = 1'b0;
    ticks(3);
    btn_in = 1'b1;
    ticks(10);
    chk("glitch_press_n", 32'(press_n), 0);
    chk("glitch_release_n", 32'(release_n), 0);
    chk("glitch_pressed", 32'(pressed), 0);
    chk("glitch_count", 32'(press_count), 1);

    // Bouncy release
    clr();
    btn_in = 1'b0;
    ticks(12);
    chk("bounce_held", 32'(pressed), 1);
    for (int i = 0; i < 10; i++) begin
      btn_in = (i % 2 == 0) ? 1'b1 : 1'b0;
      tick();
    end
    chk("bounce_no_early_release", 32'(release_n), 0);
    btn_in = 1'b1;
    e0 = cyc + 1;
    ticks(10);
    chk("bounce_release_n", 32'(release_n), 1);
    chk("bounce_release_at", 32'(release_at - e0), 6);
    chk("bounce_press_n", 32'(press_n), 1);
    chk("bounce_long_n", 32'(long_n), 0);
    chk("bounce_pressed", 32'(pressed), 0);
    chk("bounce_count", 32'(press_count), 2);

    // Short press of 10 cycles
    clr();
    btn_in = 1'b0;
    e0 = cyc + 1;
    ticks(10);
    btn_in = 1'b1;
    ticks(14);
    chk("short_press_at", 32'(press_at - e0), 6);
    chk("short_release_at", 32'(release_at - e0), 16);
    chk("short_press_n", 32'(press_n), 1);
    chk("short_release_n", 32'(release_n), 1);
    chk("short_long_n", 32'(long_n), 0);
    chk("short_count", 32'(press_count), 3);

    // 256 presses from reset wrap the count to 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ticks(2);
    chk("wrap_start_count", 32'(press_count), 0);
    clr();
    for (int p = 0; p < 256; p++) begin
      btn_in = 1'b0;
      ticks(8);
      btn_in = 1'b1;
      ticks(8);
      if (p == 254) chk("wrap_count_255", 32'(press_count), 255);
    end
    chk("wrap_press_n", 32'(press_n), 256);
    chk("wrap_count_0", 32'(press_count), 0);

    // Reset while held, then the still-held button is counted afresh
    clr();
    btn_in = 1'b0;
    ticks(8);
    chk("midrst_held", 32'(pressed), 1);
    rst = 1'b1;
    tick();
    chk("midrst_pressed", 32'(pressed), 0);
    chk("midrst_press_pulse", 32'(press_pulse), 0);
    chk("midrst_release_pulse", 32'(release_pulse), 0);
    chk("midrst_long_pulse", 32'(long_pulse), 0);
    chk("midrst_count", 32'(press_count), 0);
    rst = 1'b0;
    e0 = cyc + 1;
    ticks(10);
    chk("midrst_release_n", 32'(release_n), 0);
    chk("midrst_press_n", 32'(press_n), 2);
    chk("midrst_repress_at", 32'(press_at - e0), 6);
    chk("midrst_repress_count", 32'(press_count), 1);
    chk("midrst_repressed", 32'(pressed), 1);

    chk("strobe_overlap", 32'(clash_n), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
